// File: rtl/regfile_2r1w_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_2r1w_pkg                                              |
// | Purpose  : Shared sizing constants and types for the 2-read/1-write      |
// |            processor register file.                                      |
// | Contents : WIDTH, NREGS, AW, ZERO_REG, word_t, addr_t                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package regfile_2r1w_pkg;

   localparam int WIDTH    = 32;              // data width of each register
   localparam int NREGS    = 32;              // architectural registers (power of two)
   localparam int AW       = $clog2(NREGS);   // register index width
   localparam int ZERO_REG = 0;               // hardwired-zero register index

   typedef logic [WIDTH-1:0] word_t;
   typedef logic [AW-1:0]    addr_t;

endpackage : regfile_2r1w_pkg
`default_nettype wire

// File: rtl/regfile_2r1w_reg_word.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_2r1w_reg_word                                         |
// | Purpose  : One storage word of the register file: loads i_d when i_en    |
// |            is high on a rising clk, cleared asynchronously by clr_n.     |
// | Ports    : clk   - rising-edge clock                                     |
// |            clr_n - asynchronous active-low clear                         |
// |            i_en  - word write enable                                     |
// |            i_d   - write data                                            |
// |            o_q   - stored value                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module regfile_2r1w_reg_word
   import regfile_2r1w_pkg::*;
#(
   parameter int DATA_W = WIDTH
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_d,
   output logic [DATA_W-1:0] o_q
);

   logic [DATA_W-1:0] r_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule : regfile_2r1w_reg_word
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_2r1w                                                  |
// | Purpose  : 32 x 32-bit register file, one write port, two combinational  |
// |            read ports. Register 0 reads as zero; a same-cycle write is   |
// |            bypassed to either read port (write-before-read).             |
// | Ports    : clk     - rising-edge clock                                   |
// |            clr_n   - asynchronous active-low reset                       |
// |            we      - write enable                                        |
// |            waddr   - write register index                                |
// |            wdata   - write data                                          |
// |            raddr_a - read port A index                                   |
// |            raddr_b - read port B index                                   |
// |            rdata_a - read port A data (combinational)                    |
// |            rdata_b - read port B data (combinational)                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module regfile_2r1w
   import regfile_2r1w_pkg::*;
(
   input  logic             clk,
   input  logic             clr_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b
);

   logic [NREGS-1:0] w_wen;
   word_t            w_regs [NREGS];

   // Register 0 has no storage and can never be written.
   assign w_regs[ZERO_REG] = '0;
   assign w_wen[ZERO_REG]  = 1'b0;

   // One-hot write decode gated by we: with we low every enable is 0,
   // so an unknown waddr cannot reach any word.
   generate
      for (genvar gi = 1; gi < NREGS; gi++) begin : g_word
         assign w_wen[gi] = we && (waddr == AW'(gi));

         regfile_2r1w_reg_word #(
            .DATA_W (WIDTH)
         ) u_word (
            .clk   (clk),
            .clr_n (clr_n),
            .i_en  (w_wen[gi]),
            .i_d   (wdata),
            .o_q   (w_regs[gi])
         );
      end
   endgenerate

   // Read path per port: array mux -> zero-force -> bypass.
   word_t w_mux_a, w_mux_b;
   word_t w_rd_a,  w_rd_b;
   logic  w_wr_live;
   logic  w_hit_a, w_hit_b;

   // A write only counts as "in flight" for bypass when it targets a real
   // register and reset is not holding; this keeps reads at 0 during reset.
   assign w_wr_live = clr_n && we && (waddr != AW'(ZERO_REG));
   assign w_hit_a   = w_wr_live && (waddr == raddr_a);
   assign w_hit_b   = w_wr_live && (waddr == raddr_b);

   assign w_mux_a = w_regs[raddr_a];
   assign w_mux_b = w_regs[raddr_b];

   assign w_rd_a = (raddr_a == AW'(ZERO_REG)) ? '0 : w_mux_a;
   assign w_rd_b = (raddr_b == AW'(ZERO_REG)) ? '0 : w_mux_b;

   assign rdata_a = (!clr_n) ? '0 : (w_hit_a ? wdata : w_rd_a);
   assign rdata_b = (!clr_n) ? '0 : (w_hit_b ? wdata : w_rd_b);

endmodule : regfile_2r1w
`default_nettype wire
